p2_sprite_render: RTL and testbench

P2_SPRITE_RENDER -- requirements
Module: p2_sprite_render

---
 rtl/p2_sprite_pkg.sv | 54 +++++
 rtl/p2_anim_ctrl.sv | 90 +++++++++
 rtl/p2_sprite_render.sv | 104 ++++++++++
 tb/tb_p2_sprite_render.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/p2_sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : p2_sprite_pkg
// Description : Shared definitions for the player-2 sprite renderer: action
//               codes, sprite geometry and the sprite ROM address layout
//               {row[3:0], action[2:0], frame[2:0]}.
// Revision    : 1.0 - initial release
// ============================================================================
package p2_sprite_pkg;

    // Native sprite edge length in ROM pixels (before magnification)
    localparam int SPRITE_SIZE = 16;

    // Animation geometry
    localparam int NUM_FRAMES  = 4;
    localparam int CUR_FRAME_W = 2;

    // ROM address field widths and positions
    localparam int ROW_W          = 4;
    localparam int ACT_W          = 3;
    localparam int FRAME_W        = 3;
    localparam int ADDR_W         = ROW_W + ACT_W + FRAME_W;
    localparam int ADDR_FRAME_LSB = 0;
    localparam int ADDR_ACT_LSB   = ADDR_FRAME_LSB + FRAME_W;
    localparam int ADDR_ROW_LSB   = ADDR_ACT_LSB + ACT_W;

    typedef enum logic [ACT_W-1:0] {
        ACT_STAY  = 3'd0,
        ACT_FWD   = 3'd1,
        ACT_BACK  = 3'd2,
        ACT_PUNCH = 3'd3,
        ACT_KICK  = 3'd4
    } action_e;

    // True for the codes that launch a one-shot move; 0 and 5-7 mean "stay"
    function automatic logic is_move(input logic [ACT_W-1:0] code);
        return (code >= ACT_FWD) && (code <= ACT_KICK);
    endfunction

    function automatic logic [ADDR_W-1:0] pack_rom_addr(
        input logic [ROW_W-1:0]       row,
        input logic [ACT_W-1:0]       act,
        input logic [CUR_FRAME_W-1:0] frame
    );
        logic [ADDR_W-1:0] addr;
        addr = '0;
        addr[ADDR_ROW_LSB   +: ROW_W]   = row;
        addr[ADDR_ACT_LSB   +: ACT_W]   = act;
        addr[ADDR_FRAME_LSB +: FRAME_W] = {1'b0, frame};
        return addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/p2_anim_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : p2_anim_ctrl
// Description : Two-state animation sequencer. IDLE loops frames 0-3 of the
//               stay action; PLAY runs frames 0-3 of a move once and returns
//               to IDLE. Each frame is held for TICKS_PER_FRAME frame ticks.
// Ports       : clk, rst_n        - clock, async active-low reset
//               frame_tick        - one pulse per video frame
//               action_req/start  - requested move and its launch pulse
//               busy              - a move is playing
//               cur_action/frame  - animation position, registered
// Revision    : 1.0 - initial release
// ============================================================================
module p2_anim_ctrl
    import p2_sprite_pkg::*;
#(
    parameter int TICKS_PER_FRAME = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   frame_tick,
    input  logic [ACT_W-1:0]       action_req,
    input  logic                   action_start,
    output logic                   busy,
    output logic [ACT_W-1:0]       cur_action,
    output logic [CUR_FRAME_W-1:0] cur_frame
);

    localparam int C_TICK_W = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
    localparam logic [C_TICK_W-1:0]    C_TICK_LAST  = C_TICK_W'(TICKS_PER_FRAME - 1);
    localparam logic [CUR_FRAME_W-1:0] C_LAST_FRAME = CUR_FRAME_W'(NUM_FRAMES - 1);

    localparam logic [0:0] C_ST_IDLE = 1'b0;
    localparam logic [0:0] C_ST_PLAY = 1'b1;

    logic [0:0]             r_state_q,  w_state_d;
    logic [ACT_W-1:0]       r_action_q, w_action_d;
    logic [CUR_FRAME_W-1:0] r_frame_q,  w_frame_d;
    logic [C_TICK_W-1:0]    r_tick_q,   w_tick_d;

    always_comb begin
        w_state_d  = r_state_q;
        w_action_d = r_action_q;
        w_frame_d  = r_frame_q;
        w_tick_d   = r_tick_q;

        // An accepted start takes priority over a coincident tick, which is
        // dropped so the move always begins with a full-length frame 0.
        if ((r_state_q == C_ST_IDLE) && action_start && is_move(action_req)) begin
            w_state_d  = C_ST_PLAY;
            w_action_d = action_req;
            w_frame_d  = '0;
            w_tick_d   = '0;
        end else if (frame_tick) begin
            if (r_tick_q == C_TICK_LAST) begin
                w_tick_d = '0;
                if ((r_state_q == C_ST_PLAY) && (r_frame_q == C_LAST_FRAME)) begin
                    w_state_d  = C_ST_IDLE;
                    w_action_d = ACT_STAY;
                    w_frame_d  = '0;
                end else begin
                    // In IDLE the 2-bit frame wraps 3 -> 0 naturally
                    w_frame_d = r_frame_q + CUR_FRAME_W'(1);
                end
            end else begin
                w_tick_d = r_tick_q + C_TICK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q  <= C_ST_IDLE;
            r_action_q <= ACT_STAY;
            r_frame_q  <= '0;
            r_tick_q   <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_action_q <= w_action_d;
            r_frame_q  <= w_frame_d;
            r_tick_q   <= w_tick_d;
        end
    end

    assign busy       = (r_state_q == C_ST_PLAY);
    assign cur_action = r_action_q;
    assign cur_frame  = r_frame_q;

endmodule
`default_nettype wire

// File: rtl/p2_sprite_render.sv
`default_nettype none
// ============================================================================
// Module      : p2_sprite_render
// Description : Renders the magnified player-2 sprite onto the VGA scan.
//               Stage 0 forms the ROM address from the scan row; stage 1
//               aligns column/in-box/video/mirror with the ROM output;
//               stage 2 registers pixel_on. Animation comes from p2_anim_ctrl.
// Ports       : clk, rst_n             - clock, async active-low reset
//               pixel_x/y, video_on    - scan position and visibility
//               frame_tick             - one pulse per video frame
//               pos_x/y, facing_left   - sprite placement and mirroring
//               action_req/start       - move request and launch pulse
//               rom_addr, rom_bitmap   - external sprite ROM (1-cycle read)
//               pixel_on               - opaque sprite pixel, 2-cycle latency
//               busy, cur_action/frame - animation status
// Revision    : 1.0 - initial release
// ============================================================================
module p2_sprite_render
    import p2_sprite_pkg::*;
#(
    parameter int SCALE_SHIFT     = 2,
    parameter int TICKS_PER_FRAME = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [9:0]             pixel_x,
    input  logic [9:0]             pixel_y,
    input  logic                   video_on,
    input  logic                   frame_tick,
    input  logic [9:0]             pos_x,
    input  logic [9:0]             pos_y,
    input  logic                   facing_left,
    input  logic [ACT_W-1:0]       action_req,
    input  logic                   action_start,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [SPRITE_SIZE-1:0] rom_bitmap,
    output logic                   pixel_on,
    output logic                   busy,
    output logic [ACT_W-1:0]       cur_action,
    output logic [CUR_FRAME_W-1:0] cur_frame
);

    localparam logic [10:0] C_BOX = 11'(SPRITE_SIZE << SCALE_SHIFT);

    p2_anim_ctrl #(
        .TICKS_PER_FRAME (TICKS_PER_FRAME)
    ) u_anim_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .action_req   (action_req),
        .action_start (action_start),
        .busy         (busy),
        .cur_action   (cur_action),
        .cur_frame    (cur_frame)
    );

    // Stage 0: offsets in 11 bits so a scan left of / above the sprite
    // becomes a large value and fails the box test instead of wrapping.
    logic [10:0]      w_dx, w_dy;
    logic             w_in_box_d;
    logic [3:0]       w_col_d;
    logic [ROW_W-1:0] w_row;

    assign w_dx       = {1'b0, pixel_x} - {1'b0, pos_x};
    assign w_dy       = {1'b0, pixel_y} - {1'b0, pos_y};
    assign w_in_box_d = (w_dx < C_BOX) && (w_dy < C_BOX);
    assign w_col_d    = w_dx[SCALE_SHIFT +: 4];
    assign w_row      = w_dy[SCALE_SHIFT +: ROW_W];
    assign rom_addr   = pack_rom_addr(w_row, cur_action, cur_frame);

    // Stage 1: aligned with rom_bitmap
    logic       r_in_box_q, r_video_on_q, r_facing_q;
    logic [3:0] r_col_q;

    // Stage 2
    logic r_pixel_on_q, w_pixel_on_d;
    logic w_bit;

    // ROM bit 15 is the leftmost pixel; mirroring reads the row reversed.
    // A clear bit is opaque.
    assign w_bit        = r_facing_q ? rom_bitmap[r_col_q] : rom_bitmap[4'd15 - r_col_q];
    assign w_pixel_on_d = r_in_box_q & r_video_on_q & ~w_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_box_q   <= 1'b0;
            r_video_on_q <= 1'b0;
            r_facing_q   <= 1'b0;
            r_col_q      <= '0;
            r_pixel_on_q <= 1'b0;
        end else begin
            r_in_box_q   <= w_in_box_d;
            r_video_on_q <= video_on;
            r_facing_q   <= facing_left;
            r_col_q      <= w_col_d;
            r_pixel_on_q <= w_pixel_on_d;
        end
    end

    assign pixel_on = r_pixel_on_q;

endmodule
`default_nettype wire

// File: tb/tb_p2_sprite_render.sv
`default_nettype none
// ============================================================================
// Module      : tb_p2_sprite_render
// Description : Self-checking bench for p2_sprite_render with a behavioural
//               ROM, a tick-count animation model and a pixel model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_p2_sprite_render;

    localparam int TPF = 6;
    localparam int SS  = 2;
    localparam int BOX = 16 << SS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  pixel_x = '0, pixel_y = '0, pos_x = '0, pos_y = '0;
    logic        video_on = 1'b0, frame_tick = 1'b0, facing_left = 1'b0;
    logic [2:0]  action_req = '0;
    logic        action_start = 1'b0;
    logic [9:0]  rom_addr;
    logic [15:0] rom_bitmap = '0;
    logic        pixel_on, busy;
    logic [2:0]  cur_action;
    logic [1:0]  cur_frame;

    always #5 clk = ~clk;

    p2_sprite_render #(
        .SCALE_SHIFT     (SS),
        .TICKS_PER_FRAME (TPF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .video_on     (video_on),
        .frame_tick   (frame_tick),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .facing_left  (facing_left),
        .action_req   (action_req),
        .action_start (action_start),
        .rom_addr     (rom_addr),
        .rom_bitmap   (rom_bitmap),
        .pixel_on     (pixel_on),
        .busy         (busy),
        .cur_action   (cur_action),
        .cur_frame    (cur_frame)
    );

    // Sprite ROM contents: row 0 is fixed, other rows are a hash of the address
    function automatic logic [15:0] rom_word(input int row, input int act, input int frm);
        if (row == 0) return 16'hFC3F;
        return 16'((row * 935) ^ (act * 497) ^ (frm * 197) ^ 16'h5A5A);
    endfunction

    always @(posedge clk)
        rom_bitmap <= rom_word(int'(rom_addr[9:6]), int'(rom_addr[5:3]), int'(rom_addr[2:0]));

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string name, input int got, input int exp);
        n_tot++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, got, exp);
    endtask

    // Animation model: ticks elapsed since the current mode began
    int m_play = 0, m_act = 0, m_n = 0;
    int pend = 0;

    function automatic int m_frame();
        return m_play != 0 ? m_n / TPF : (m_n / TPF) % 4;
    endfunction

    function automatic int exp_pix(input int px, input int py, input int qx, input int qy,
                                   input int fl, input int von, input int act, input int frm);
        int dx, dy, c, r;
        logic [15:0] w;
        logic b;
        dx = px - qx;
        dy = py - qy;
        if (von == 0 || dx < 0 || dx >= BOX || dy < 0 || dy >= BOX) return 0;
        c = dx >> SS;
        r = dy >> SS;
        w = rom_word(r, act, frm);
        b = (fl != 0) ? w[c] : w[15 - c];
        return b ? 0 : 1;
    endfunction

    task automatic step(input bit tick, input bit start, input logic [2:0] req);
        int e_now;
        frame_tick   = tick;
        action_start = start;
        action_req   = req;
        e_now = exp_pix(int'(pixel_x), int'(pixel_y), int'(pos_x), int'(pos_y),
                        int'(facing_left), int'(video_on), m_act, m_frame());
        if (m_play == 0 && start && req >= 3'd1 && req <= 3'd4) begin
            m_play = 1;
            m_act  = int'(req);
            m_n    = 0;
        end else if (tick) begin
            m_n++;
            if (m_play != 0 && m_n == 4 * TPF) begin
                m_play = 0;
                m_act  = 0;
                m_n    = 0;
            end
        end
        @(posedge clk);
        #1;
        frame_tick   = 1'b0;
        action_start = 1'b0;
        check("busy", int'(busy), m_play);
        check("cur_action", int'(cur_action), m_act);
        check("cur_frame", int'(cur_frame), m_frame());
        check("pixel_on", int'(pixel_on), pend);
        pend = e_now;
    endtask

    typedef struct {
        string name;
        int px, py, qx, qy, fl, von, exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{"origin",      100, 50, 100, 50, 0, 1, 0};
        vecs[1]  = '{"col6",        124, 50, 100, 50, 0, 1, 1};
        vecs[2]  = '{"col6_left",   124, 50, 100, 50, 1, 1, 1};
        vecs[3]  = '{"origin_left", 100, 50, 100, 50, 1, 1, 0};
        vecs[4]  = '{"col5",        120, 50, 100, 50, 0, 1, 0};
        vecs[5]  = '{"col7",        128, 50, 100, 50, 0, 1, 1};
        vecs[6]  = '{"col15",       163, 53, 100, 50, 0, 1, 0};
        vecs[7]  = '{"right_out",   164, 50, 100, 50, 0, 1, 0};
        vecs[8]  = '{"video_off",   124, 50, 100, 50, 0, 0, 0};
        vecs[9]  = '{"no_wrap",       5, 50, 1000, 50, 0, 1, 0};
        vecs[10] = '{"above",       124, 49, 100, 50, 0, 1, 0};
        vecs[11] = '{"col9_left",   136, 50, 100, 50, 1, 1, 1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_action", int'(cur_action), 0);
        check("rst_frame", int'(cur_frame), 0);
        check("rst_pixel", int'(pixel_on), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle loop with a frame tick every 100 cycles
        for (int i = 0; i < 2400; i++) begin
            step(i % 100 == 99, 1'b0, 3'd0);
            if (i == 599)  check("idle_f1", int'(cur_frame), 1);
            if (i == 1799) check("idle_f3", int'(cur_frame), 3);
            if (i == 2399) check("idle_wrap", int'(cur_frame), 0);
        end

        // Punch plays once then returns to idle
        step(1'b0, 1'b1, 3'd3);
        check("punch_busy", int'(busy), 1);
        check("punch_act", int'(cur_action), 3);
        check("punch_f0", int'(cur_frame), 0);
        for (int i = 0; i < 24; i++) begin
            step(1'b1, 1'b0, 3'd0);
            if (i == 22) begin
                check("punch_f3", int'(cur_frame), 3);
                check("punch_busy_late", int'(busy), 1);
            end
            step(1'b0, 1'b0, 3'd0);
            step(1'b0, 1'b0, 3'd0);
        end
        check("punch_done_busy", int'(busy), 0);
        check("punch_done_act", int'(cur_action), 0);
        check("punch_done_f", int'(cur_frame), 0);

        // Start coincident with a tick; then an ignored start during PLAY
        step(1'b1, 1'b1, 3'd1);
        check("fwd_act", int'(cur_action), 1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 3'd0);
        check("tick_discarded", int'(cur_frame), 0);
        step(1'b1, 1'b0, 3'd0);
        check("fwd_f1", int'(cur_frame), 1);
        step(1'b0, 1'b1, 3'd4);
        check("no_interrupt", int'(cur_action), 1);
        for (int k = 0; k < 200 && busy; k++) step(1'b1, 1'b0, 3'd0);
        check("fwd_end", int'(busy), 0);
        step(1'b0, 1'b1, 3'd6);
        check("code6_ignored", int'(busy), 0);
        step(1'b0, 1'b1, 3'd0);
        check("code0_ignored", int'(busy), 0);

        // Pixel pipeline vectors
        foreach (vecs[i]) begin
            pixel_x     = 10'(vecs[i].px);
            pixel_y     = 10'(vecs[i].py);
            pos_x       = 10'(vecs[i].qx);
            pos_y       = 10'(vecs[i].qy);
            facing_left = vecs[i].fl[0];
            video_on    = vecs[i].von[0];
            repeat (3) step(1'b0, 1'b0, 3'd0);
            check(vecs[i].name, int'(pixel_on), vecs[i].exp);
        end

        // Randomized traffic around the sprite
        for (int i = 0; i < 3000; i++) begin
            int qx, qy, px, py;
            qx = int'($urandom_range(0, 1023));
            qy = int'($urandom_range(0, 1023));
            px = qx + int'($urandom_range(0, 80)) - 8;
            py = qy + int'($urandom_range(0, 80)) - 8;
            pos_x       = 10'(qx);
            pos_y       = 10'(qy);
            pixel_x     = 10'(px & 1023);
            pixel_y     = 10'(py & 1023);
            facing_left = $urandom_range(0, 1) == 1;
            video_on    = $urandom_range(0, 7) != 0;
            step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, 3'($urandom_range(0, 7)));
        end

        // Reset mid-PLAY at frame 2
        step(1'b0, 1'b0, 3'd0);
        step(1'b0, 1'b0, 3'd0);
        for (int k = 0; k < 200 && busy; k++) step(1'b1, 1'b0, 3'd0);
        step(1'b0, 1'b1, 3'd2);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 3'd0);
        check("pre_rst_f2", int'(cur_frame), 2);
        check("pre_rst_busy", int'(busy), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_act", int'(cur_action), 0);
        check("mid_rst_frame", int'(cur_frame), 0);
        check("mid_rst_pixel", int'(pixel_on), 0);
        m_play = 0;
        m_act  = 0;
        m_n    = 0;
        pend   = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 3'd0);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_frame", int'(cur_frame), 0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 3'd0);
        check("post_rst_f1", int'(cur_frame), 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
